// File: rtl/add_sequencer_if.sv
// Handshake/operand/result bundle for add_sequencer.
// Carries the Sub select only when ADD_SEQ_SUB_EN is defined.
interface add_sequencer_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
`ifdef ADD_SEQ_SUB_EN
   logic         Sub;
`endif
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] S;
   logic         Carry;
   logic         Overflow;

`ifdef ADD_SEQ_SUB_EN
   modport master (output start, A, B, Sub, input ready, busy, done, S, Carry, Overflow);
   modport slave  (input start, A, B, Sub, output ready, busy, done, S, Carry, Overflow);
`else
   modport master (output start, A, B, input ready, busy, done, S, Carry, Overflow);
   modport slave  (input start, A, B, output ready, busy, done, S, Carry, Overflow);
`endif
endinterface

// File: rtl/add_sequencer.sv
// Nibble-serial W-bit adder: one 4-bit slice reused LSB-first, NIBBLES+1 cycles per operation.
// Optional subtract mode (Sub port) is built when macro ADD_SEQ_SUB_EN is defined.
module add_sequencer #(
   parameter int NIBBLES = 4
) (
   input logic            clk,
   input logic            rst_n,
   add_sequencer_if.slave bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic logic [4:0] add_slice(input logic [3:0] a, input logic [3:0] b,
                                            input logic cin);
      return {1'b0, a} + {1'b0, b} + {4'b0000, cin};
   endfunction

   state_t        state;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [IW-1:0] idx;
   logic          cin;
   logic [W-1:0]  s_q;
   logic          carry_q;
   logic          ovf_q;
   logic          ready_q;
   logic          busy_q;
   logic          done_q;
   logic [3:0]    a_nib;
   logic [3:0]    b_nib;
   logic [4:0]    sum;

`ifdef ADD_SEQ_SUB_EN
   logic          sub_q;
   // Subtraction is A + ~B + 1; the +1 enters as the initial carry-in.
   assign b_nib = b_q[{idx, 2'b00} +: 4] ^ {4{sub_q}};
`else
   assign b_nib = b_q[{idx, 2'b00} +: 4];
`endif
   assign a_nib = a_q[{idx, 2'b00} +: 4];
   assign sum   = add_slice(a_nib, b_nib, cin);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx     <= '0;
         cin     <= 1'b0;
         s_q     <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
         sub_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q     <= bus.A;
                  b_q     <= bus.B;
                  idx     <= '0;
`ifdef ADD_SEQ_SUB_EN
                  sub_q   <= bus.Sub;
                  cin     <= bus.Sub;
`else
                  cin     <= 1'b0;
`endif
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               s_q[{idx, 2'b00} +: 4] <= sum[3:0];
               cin <= sum[4];
               if (idx == IW'(NIBBLES - 1)) begin
                  carry_q <= sum[4];
                  ovf_q   <= (a_nib[3] == b_nib[3]) && (sum[3] != a_nib[3]);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state   <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready    = ready_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.S        = s_q;
   assign bus.Carry    = carry_q;
   assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_add_sequencer.sv
// Directed self-checking bench for add_sequencer (NIBBLES=4); drives on and samples at negedge.
module tb_add_sequencer;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   add_sequencer_if #(.NIBBLES(4)) bus ();

   add_sequencer #(.NIBBLES(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulses start with operands, optionally injects a second start in RUN,
   // and records the cycle of the first done plus the number of done pulses.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic inject, output int first_done, output int ndone,
                         output logic ready1, output logic busy1);
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
`ifdef ADD_SEQ_SUB_EN
      bus.Sub   = sub;
`else
      if (sub) $display("note: Sub requested but ADD_SEQ_SUB_EN undefined");
`endif
      @(posedge clk);
      first_done = 0;
      ndone      = 0;
      ready1     = 1'b1;
      busy1      = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) begin
            ready1 = bus.ready;
            busy1  = bus.busy;
            if (inject) begin
               bus.start = 1'b1;
               bus.A     = 16'hFFFF;
               bus.B     = 16'hFFFF;
            end else begin
               bus.start = 1'b0;
               bus.A     = ~a;
               bus.B     = ~b;
            end
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done === 1'b1) begin
            ndone++;
            if (first_done == 0) first_done = c;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
      checks++; if (bus.S !== 16'h0000) begin errors++; $display("FAIL reset_S got %h want 0000", bus.S); end
      checks++; if (bus.Carry !== 1'b0) begin errors++; $display("FAIL reset_Carry got %b want 0", bus.Carry); end
      checks++; if (bus.Overflow !== 1'b0) begin errors++; $display("FAIL reset_Overflow got %b want 0", bus.Overflow); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic inject, input logic [15:0] exp_s,
                          input logic exp_c, input logic exp_o);
      int fd, nd;
      logic r1, b1;
      run_op(a, b, sub, inject, fd, nd, r1, b1);
      checks++; if (fd !== 5) begin errors++; $display("FAIL %s_latency got %0d want 5", name, fd); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL %s_done_count got %0d want 1", name, nd); end
      checks++; if (r1 !== 1'b0 || b1 !== 1'b1) begin errors++; $display("FAIL %s_run_flags got ready=%b busy=%b want ready=0 busy=1", name, r1, b1); end
      checks++; if (bus.S !== exp_s) begin errors++; $display("FAIL %s_S got %h want %h", name, bus.S, exp_s); end
      checks++; if (bus.Carry !== exp_c) begin errors++; $display("FAIL %s_Carry got %b want %b", name, bus.Carry, exp_c); end
      checks++; if (bus.Overflow !== exp_o) begin errors++; $display("FAIL %s_Overflow got %b want %b", name, bus.Overflow, exp_o); end
      checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL %s_ready_after got %b want 1", name, bus.ready); end
   endtask

   task automatic test_reset_in_run();
      int nd;
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 16'h1111;
      bus.B     = 16'h2222;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_flags got ready=%b busy=%b done=%b want 1 0 0", bus.ready, bus.busy, bus.done); end
      checks++; if (bus.S !== 16'h0000 || bus.Carry !== 1'b0 || bus.Overflow !== 1'b0) begin errors++; $display("FAIL abort_result got S=%h C=%b O=%b want 0000 0 0", bus.S, bus.Carry, bus.Overflow); end
      nd = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c == 1) rst_n = 1'b1;
         if (bus.done === 1'b1) nd++;
      end
      checks++; if (nd !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", nd); end
   endtask

   task automatic test_hold();
      logic [15:0] s0;
      s0 = 16'h8000;
      repeat (4) @(negedge clk);
      checks++; if (bus.S !== s0 || bus.Overflow !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL hold got S=%h O=%b done=%b want 8000 1 0", bus.S, bus.Overflow, bus.done); end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
`ifdef ADD_SEQ_SUB_EN
      bus.Sub   = 1'b0;
`endif
      test_reset();
      test_op("basic",    16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      test_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      test_op("overflow", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      test_hold();
      test_op("negovf",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      test_op("ignore",   16'h1111, 16'h2222, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);
      test_reset_in_run();
      test_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
`ifdef ADD_SEQ_SUB_EN
      test_op("sub",      16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/add_sequencer.md
ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4: number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request; accepted only when ready=1.
REQ-005 The block SHALL have ports A and B, inputs, W bits: operands, sampled on the accepting edge.
REQ-006 The block SHALL have port ready, output, 1 bit: high in IDLE only.
REQ-007 The block SHALL have port busy, output, 1 bit: high in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-009 The block SHALL have port S, output, W bits: result.
REQ-010 The block SHALL have port Carry, output, 1 bit: carry out of the MSB nibble.
REQ-011 The block SHALL have port Overflow, output, 1 bit: signed overflow of the W-bit operation.

Function
REQ-012 The block SHALL use one 4-bit add slice with carry-in, computing {c,s} = a_nib + b_nib + cin, reused once per cycle.
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, the block SHALL capture A and B into operand registers, clear the nibble index and carry register, and enter RUN.
REQ-015 In RUN, each cycle SHALL add nibble i (LSB first), write s to S[4i+3:4i], store c as next cin, and increment i.
REQ-016 After nibble NIBBLES-1, the block SHALL load Carry=c and Overflow=(a_msb==b_eff_msb)&&(s_msb!=a_msb), and enter DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 Latency: start accepted at edge k -> done high in cycle following edge k+NIBBLES; total NIBBLES+1 cycles per operation.
REQ-019 start SHALL be ignored in RUN and DONE; no queuing; operand registers SHALL NOT change while busy.
REQ-020 S, Carry and Overflow SHALL hold their last result from DONE until the next accepted start, then update nibble-wise.
REQ-021 Operand changes on A/B after the accepting edge SHALL NOT affect the result.
REQ-022 Index wrap SHALL NOT occur: i is cleared on accept and never exceeds NIBBLES-1.

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, ready=1, busy=0, done=0, S=0, Carry=0, Overflow=0, and clear index, carry and operand registers.
REQ-024 Reset during RUN or DONE SHALL abort the operation with no done pulse; the first start after deassertion SHALL be accepted normally.

Configuration
REQ-025 With macro ADD_SEQ_SUB_EN defined, the block SHALL add input port Sub (1 bit, sampled with A/B): Sub=1 computes A-B via inverted B nibbles and initial cin=1; Carry=1 means no borrow.
REQ-026 Without ADD_SEQ_SUB_EN, port Sub SHALL be absent and the block SHALL perform addition only, with initial cin=0.

Verification
REQ-027 The bench SHALL reset, then start with A=16'h1234, B=16'h4321 -> S=16'h5555, Carry=0, Overflow=0, done in 5th cycle after accept.
REQ-028 The bench SHALL start with A=16'hFFFF, B=16'h0001 -> S=16'h0000, Carry=1, Overflow=0 (full ripple through all nibbles).
REQ-029 The bench SHALL start with A=16'h7FFF, B=16'h0001 -> S=16'h8000, Carry=0, Overflow=1.
REQ-030 The bench SHALL pulse start plus new operands during RUN -> request ignored; result is first operation's; exactly one done pulse.
REQ-031 The bench SHALL assert rst_n=0 in the 2nd RUN cycle -> immediate IDLE, all outputs 0, no done; next start 16'h0F0F+16'h00F1 -> S=16'h1000.
REQ-032 With ADD_SEQ_SUB_EN, the bench SHALL start with Sub=1, A=16'h0005, B=16'h0007 -> S=16'hFFFE, Carry=0, Overflow=0.
